// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the delay-line ring-buffer controller.
package delay_line_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN} dl_state_t;

  // Widest address supported by the clamp helper; callers zero-extend into it.
  localparam int unsigned MaxAddrWidth = 16;

  // A requested delay of zero behaves as a delay of one sample.
  function automatic logic [MaxAddrWidth-1:0] clamp_delay(input logic [MaxAddrWidth-1:0] d);
    return (d == '0) ? MaxAddrWidth'(1) : d;
  endfunction

endpackage

// File: rtl/delay_line_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module delay_line_ram #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout
);

  localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // dout holds between reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
    if (rd_en) dout <= mem[rd_addr];
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Ring-buffer controller: writes each accepted sample to RAM and reads back the one
// accepted delay_q samples earlier, producing a sample stream delayed by delay_q.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     ram_wr_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     filling
);

  dl_state_t                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDRESS_WIDTH-1:0] delay_q, delay_d;
  logic                     out_valid_q;
  logic [DATA_WIDTH-1:0]    out_data_q;

  logic                     accept;
  logic                     delay_chg;
  logic                     rd_en;
  logic [ADDRESS_WIDTH-1:0] delay_eff;

  assign delay_eff = ADDRESS_WIDTH'(clamp_delay(MaxAddrWidth'(delay)));

  always_comb begin
    // Reset masks accept so every RAM strobe is low while rst is asserted.
    accept     = enable & in_valid & ~rst;
    delay_chg  = (state_q != IDLE) && (delay_eff != delay_q);
    state_d    = state_q;
    wr_ptr_d   = accept ? wr_ptr_q + ADDRESS_WIDTH'(1) : wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    delay_d    = delay_q;
    rd_en      = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      if (state_q == IDLE) begin
        wr_ptr_d   = '0;
        fill_cnt_d = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          delay_d    = delay_eff;
          fill_cnt_d = '0;
          state_d    = FILL;
        end
        FILL: begin
          if (delay_chg) begin
            delay_d    = delay_eff;
            fill_cnt_d = '0;
          end else if (accept) begin
            fill_cnt_d = fill_cnt_q + ADDRESS_WIDTH'(1);
            if (fill_cnt_d == delay_q) state_d = RUN;
          end
        end
        RUN: begin
          // A new delay forces a refill; that cycle's sample is still written.
          if (delay_chg) begin
            delay_d    = delay_eff;
            fill_cnt_d = '0;
            state_d    = FILL;
          end else begin
            rd_en = accept;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ram_wr_en   = accept;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_din     = accept ? in_data : '0;
  assign ram_rd_en   = rd_en;
  assign ram_rd_addr = rd_en ? wr_ptr_q - delay_q : '0;

  assign filling   = (state_q == FILL);
  assign out_valid = out_valid_q;
  // RAM read data lands the cycle out_valid is high; hold the last sample otherwise.
  assign out_data  = out_valid_q ? ram_dout : out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      delay_q     <= ADDRESS_WIDTH'(1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      delay_q     <= delay_d;
      out_valid_q <= rd_en;
      if (out_valid_q) out_data_q <= ram_dout;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl with a RAM alongside; checks against a sample-history model.
module tb_delay_line_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_RUN  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [AW-1:0] delay;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_din;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_dout;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          filling;

  int checks   = 0;
  int failures = 0;

  // Reference model: every sample accepted since the pointer was last cleared.
  logic [DW-1:0] hist[$];
  int            m_mode = M_IDLE;
  int            m_d    = 1;
  int            m_fill = 0;
  bit            have_out = 1'b0;
  logic [DW-1:0] last_out = '0;

  always #5 clk = ~clk;

  delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .delay      (delay),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_din    (ram_din),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_dout   (ram_dout),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .filling    (filling)
  );

  delay_line_ram #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ram (
    .clk    (clk),
    .wr_en  (ram_wr_en),
    .wr_addr(ram_wr_addr),
    .din    (ram_din),
    .rd_en  (ram_rd_en),
    .rd_addr(ram_rd_addr),
    .dout   (ram_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: drive, check RAM-side strobes, step model, check outputs.
  task automatic cyc(input bit en, input bit iv, input int dl, input int d);
    int            eff;
    int            sz;
    bit            acc;
    bit            rd;
    logic [DW-1:0] rdata;
    enable   = en;
    in_valid = iv;
    delay    = dl[AW-1:0];
    in_data  = d[DW-1:0];
    #1;
    eff   = (dl == 0) ? 1 : dl;
    acc   = en && iv;
    sz    = hist.size();
    rd    = en && (m_mode == M_RUN) && (eff == m_d) && acc;
    rdata = '0;
    chk("wr_en", 32'(ram_wr_en), 32'(acc));
    if (acc) begin
      chk("wr_addr", 32'(ram_wr_addr), 32'(sz % 16));
      chk("din", 32'(ram_din), 32'(d[DW-1:0]));
    end
    chk("rd_en", 32'(ram_rd_en), 32'(rd));
    if (rd) begin
      chk("rd_addr", 32'(ram_rd_addr), 32'((sz - m_d) % 16));
      rdata = hist[sz - m_d];
    end

    if (!en) begin
      if (m_mode == M_IDLE) hist.delete();
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE || eff != m_d) begin
      m_d    = eff;
      m_fill = 0;
      m_mode = M_FILL;
    end else if (m_mode == M_FILL && acc) begin
      m_fill++;
      if (m_fill == m_d) m_mode = M_RUN;
    end
    if (acc) hist.push_back(d[DW-1:0]);

    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(rd));
    chk("filling", 32'(filling), 32'(m_mode == M_FILL));
    if (rd) begin
      chk("out_data", 32'(out_data), 32'(rdata));
      last_out = rdata;
      have_out = 1'b1;
    end else if (have_out) begin
      chk("out_hold", 32'(out_data), 32'(last_out));
    end
  endtask

  initial begin
    bit pat[4];
    int dl;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with enable and in_valid asserted: nothing may be written.
    rst      = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    delay    = 4'd3;
    #1;
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_filling", 32'(filling), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en_2", 32'(ram_wr_en), 32'd0);
    chk("rst_filling_2", 32'(filling), 32'd0);
    chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("post_rst_filling", 32'(filling), 32'd0);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // delay=3, samples 1,2,3,...
    cyc(1'b1, 1'b0, 3, 0);
    for (int i = 1; i <= 12; i++) cyc(1'b1, 1'b1, 3, i);

    // delay=15 with continuous random samples across the address wrap.
    for (int i = 0; i < 42; i++) cyc(1'b1, 1'b1, 15, int'($urandom_range(0, 255)));

    // Sparse input in RUN: in_valid pattern 1,0,0,1.
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 4, int'($urandom_range(0, 255)));
    for (int i = 0; i < 24; i++) cyc(1'b1, pat[i % 4], 4, int'($urandom_range(0, 255)));

    // Delay change 3 -> 5 mid-RUN.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 3, int'($urandom_range(0, 255)));
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 5, int'($urandom_range(0, 255)));

    // delay=0 acts as 1; then drop enable and refill from address 0.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 0, int'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 0, int'($urandom_range(0, 255)));
    chk("idle_wr_addr", 32'(ram_wr_addr), 32'd0);
    cyc(1'b1, 1'b0, 2, 0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 2, int'($urandom_range(0, 255)));

    // Random mix of enable, valid and delay changes.
    dl = 6;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) dl = int'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), dl,
          int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
